mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 147 ++++++++++++++
 tb/tb_mdu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MDU_DIV_EN to include the DIV/DIVU datapath; without it those ops are no-ops.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);

    logic [0:0]  state;
    logic [3:0]  count;
    logic [2:0]  opReg;
    logic [31:0] aReg;
    logic [31:0] bReg;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [63:0] prodSigned;
    logic [63:0] prodUnsigned;
    logic [31:0] resHi;
    logic [31:0] resLo;

    // The low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
    assign prodSigned   = {{32{aReg[31]}}, aReg} * {{32{bReg[31]}}, bReg};
    assign prodUnsigned = {32'd0, aReg} * {32'd0, bReg};

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    logic        divZero;
    logic        divOverflow;
    logic [31:0] safeB;
    logic [31:0] quoSigned;
    logic [31:0] remSigned;
    logic [31:0] quoUnsigned;
    logic [31:0] remUnsigned;

    // Dividing by 1 instead of 0 or -1 keeps the arithmetic defined; for MIN/-1 it yields MIN rem 0 directly.
    assign divZero     = (bReg == 32'd0);
    assign divOverflow = (aReg == 32'h8000_0000) && (bReg == 32'hFFFF_FFFF);
    assign safeB       = (divZero || divOverflow) ? 32'd1 : bReg;
    assign quoSigned   = $signed(aReg) / $signed(safeB);
    assign remSigned   = $signed(aReg) % $signed(safeB);
    assign quoUnsigned = aReg / safeB;
    assign remUnsigned = aReg % safeB;
`endif

    always_comb begin
        resHi = hiReg;
        resLo = loReg;
        case (opReg)
            OP_MULT:  {resHi, resLo} = prodSigned;
            OP_MULTU: {resHi, resLo} = prodUnsigned;
`ifdef MDU_DIV_EN
            OP_DIV: begin
                if (!divZero) begin
                    resHi = remSigned;
                    resLo = quoSigned;
                end
            end
            OP_DIVU: begin
                if (!divZero) begin
                    resHi = remUnsigned;
                    resLo = quoUnsigned;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            count <= 4'd0;
            opReg <= 3'd0;
            aReg  <= 32'd0;
            bReg  <= 32'd0;
            hiReg <= 32'd0;
            loReg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDUOp)
                            OP_MULT, OP_MULTU: begin
                                opReg <= MDUOp;
                                aReg  <= A;
                                bReg  <= B;
                                count <= MULT_LOAD;
                                state <= RUN;
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                opReg <= MDUOp;
                                aReg  <= A;
                                bReg  <= B;
                                count <= DIV_LOAD;
                                state <= RUN;
                            end
`endif
                            OP_MTHI: hiReg <= A;
                            OP_MTLO: loReg <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Start is deliberately ignored here; the last busy edge commits the result.
                    if (count == 4'd1) begin
                        hiReg <= resHi;
                        loReg <= resLo;
                        count <= 4'd0;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state == RUN);
    assign HI   = hiReg;
    assign LO   = loReg;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of op vectors plus hand-written sequences for
// in-flight Start, operand changes during RUN, and asynchronous reset abort.
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          keep;
        logic [31:0] hi;
        logic [31:0] lo;
    } VecRecord;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } ExpectRecord;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    ExpectRecord sb[$];
    VecRecord vecs[$];

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at an edge+#1 with a run in flight and `done` busy cycles already elapsed.
    task automatic finishRun(input int expCycles, input int done);
        int cyc;
        ExpectRecord e;
        cyc = done;
        while (Busy === 1'b1 && cyc < 40) begin
            checkOutput("holdDuringRun", {HI, LO}, {mHi, mLo});
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("busyCycles", 64'(cyc), 64'(expCycles));
        if (sb.size() == 0) begin
            checkOutput("scoreboardEmpty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("resultHiLo", {HI, LO}, {e.hi, e.lo});
            mHi = e.hi;
            mLo = e.lo;
        end
    endtask

    task automatic applyStimulus(input VecRecord v);
        bit accepted;
        int n;
        logic [31:0] eHi;
        logic [31:0] eLo;
        accepted = (v.op <= 3'd1) || (DIV_EN && (v.op == 3'd2 || v.op == 3'd3));
        n = (v.op <= 3'd1) ? MULT_N : DIV_N;
        eHi = mHi;
        eLo = mLo;
        if (v.op == 3'd4) eHi = v.a;
        else if (v.op == 3'd5) eLo = v.a;
        else if (accepted && !v.keep) begin
            eHi = v.hi;
            eLo = v.lo;
        end
        @(negedge clk);
        Start = 1'b1;
        MDUOp = v.op;
        A = v.a;
        B = v.b;
        if (accepted) sb.push_back('{eHi, eLo});
        @(posedge clk); #1;
        Start = 1'b0;
        A = $urandom;
        B = $urandom;
        checkOutput("busyAfterStart", 64'(Busy), 64'(accepted));
        if (accepted) begin
            finishRun(n, 0);
        end else begin
            checkOutput("immediateHiLo", {HI, LO}, {eHi, eLo});
            mHi = eHi;
            mLo = eLo;
        end
    endtask

    initial begin
        vecs.push_back('{3'd4, 32'h0000_0011, 32'h0,         1'b0, 32'h0,         32'h0});
        vecs.push_back('{3'd5, 32'h0000_0022, 32'h0,         1'b0, 32'h0,         32'h0});
        vecs.push_back('{3'd2, 32'h0000_0005, 32'h0,         1'b1, 32'h0,         32'h0});
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'h2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'h0000_0007, 32'h2,         1'b0, 32'h0000_0001, 32'h0000_0003});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0000_000F, 32'h0FFF_FFFF});
        vecs.push_back('{3'd3, 32'h0000_0009, 32'h0,         1'b1, 32'h0,         32'h0});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h2,         1'b0, 32'h0000_0001, 32'hFFFF_FFFE});
        vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd0, 32'h0000_0003, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{3'd6, 32'hAAAA_AAAA, 32'h5,         1'b0, 32'h0,         32'h0});
        vecs.push_back('{3'd7, 32'h5555_5555, 32'h5,         1'b0, 32'h0,         32'h0});
        vecs.push_back('{3'd1, 32'h1234_5678, 32'h0,         1'b0, 32'h0,         32'h0});

        Reset = 1'b0;
        Start = 1'b0;
        MDUOp = 3'd0;
        A = 32'd0;
        B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", 64'(Busy), 64'd0);
        checkOutput("resetHiLo", {HI, LO}, 64'd0);
        @(negedge clk);
        Reset = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // MULT in flight: operands change and an MTHI is pulsed two cycles in.
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd0; A = 32'd7; B = 32'd3;
        sb.push_back('{32'd0, 32'd21});
        @(posedge clk); #1;
        Start = 1'b0; A = 32'hFFFF_0000; B = 32'h0000_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd4; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        @(posedge clk); #1;
        Start = 1'b0;
        checkOutput("busyIgnoresStart", 64'(Busy), 64'd1);
        finishRun(MULT_N, 2);

        applyStimulus('{3'd4, 32'h0000_0055, 32'h0, 1'b0, 32'h0, 32'h0});

        // Asynchronous reset between edges while a MULT is in flight.
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd0; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("busyBeforeAbort", 64'(Busy), 64'd1);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        checkOutput("asyncResetBusy", 64'(Busy), 64'd0);
        checkOutput("asyncResetHiLo", {HI, LO}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        repeat (MULT_N + 2) @(posedge clk);
        #1;
        checkOutput("postAbortBusy", 64'(Busy), 64'd0);
        checkOutput("postAbortHiLo", {HI, LO}, 64'd0);
        mHi = 32'd0;
        mLo = 32'd0;

        applyStimulus('{3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        checkOutput("scoreboardDrained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
